b_wordline_fifo: RTL and testbench
==================================

B_WORDLINE_FIFO -- requirements
Module: b_wordline_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of one wordline entry in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port flush  input  1  synchronous clear of all entries.
REQ-005 The block SHALL have port push_valid  input  1  upstream offers push_data.
REQ-006 The block SHALL have port push_ready  output  1  the block accepts an entry this cycle.
REQ-007 The block SHALL have port push_data  input  DATA_WIDTH  the entry to store.
REQ-008 The block SHALL have port pop_valid  output  1  pop_data holds the oldest entry.
REQ-009 The block SHALL have port pop_ready  input  1  downstream consumes the entry this cycle.
REQ-010 The block SHALL have port pop_data  output  DATA_WIDTH  the oldest stored entry.
REQ-011 The block SHALL have port count  output  BSIZE_LOG2  the number of entries held, 0..BSIZE.

Function
REQ-012 The block SHALL provide exactly BSIZE (10) wordline entries of storage.
REQ-013 A push SHALL occur when push_valid && push_ready, and a pop SHALL occur when pop_valid && pop_ready.
REQ-014 Read and write pointers SHALL be BSIZE_LOG2 bits wide, increment by 1 per pop or push respectively, and wrap from BSIZE-1 (9) to 0, never reaching 10..15.
REQ-015 The state machine SHALL have the states EMPTY, ACTIVE and FULL.
REQ-016 From EMPTY, a push SHALL move the state to ACTIVE.
REQ-017 From ACTIVE, a pop-only cycle with count==1 SHALL move the state to EMPTY, and a push-only cycle with count==BSIZE-1 SHALL move it to FULL.
REQ-018 From FULL, a pop SHALL move the state to ACTIVE.
REQ-019 push_ready SHALL equal (state != FULL), and pop_valid SHALL equal (state != EMPTY); both SHALL be driven directly from state, with no combinational path from push_valid or pop_ready.
REQ-020 pop_data SHALL be the storage entry at the read pointer, shown without a read-enable cycle (first-word fall-through).
REQ-021 Latency SHALL be one cycle: a push in cycle N makes pop_valid high in cycle N+1 when the block was EMPTY; there SHALL be no empty-to-output bypass.
REQ-022 A simultaneous push and pop in ACTIVE SHALL leave count and state unchanged while both pointers advance.
REQ-023 Simultaneous push and pop SHALL be impossible in EMPTY and in FULL, because pop_valid or push_ready is low there.
REQ-024 flush SHALL take priority over push and pop; in the next cycle both pointers and count SHALL be 0, state SHALL be EMPTY, and the storage contents SHALL be unchanged.
REQ-025 count SHALL increment on push-only, decrement on pop-only, and never exceed BSIZE.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously reset to: state EMPTY, pointers 0, count 0, push_ready 1, pop_valid 0.
REQ-027 During reset, pop_data SHALL be don't-care and storage SHALL not be reset.
REQ-028 A reset asserted mid-operation SHALL discard all entries; the first cycle after deassertion SHALL behave as EMPTY.

Configuration
REQ-029 When B_WORDLINE_FIFO_STATS_EN is defined, the block SHALL add output high_water  BSIZE_LOG2, the maximum count seen since reset.
REQ-030 high_water SHALL be cleared by rst_n only, not by flush, and SHALL update one cycle after count rises.
REQ-031 When B_WORDLINE_FIFO_STATS_EN is undefined, the port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-032 BSIZE and BSIZE_LOG2 SHALL be imported from mixedInclude_package and SHALL not be redefined.
REQ-033 The typedefs bptr_t (logic [BSIZE_LOG2-1:0]) and b_fifo_state_t (the enum EMPTY/ACTIVE/FULL) SHALL live in the shared package.
REQ-034 One sub-module, b_wordline_ptr (mod-BSIZE wrap counter with inc and clr inputs), SHALL be instantiated twice, for the read and write pointers.

Verification
REQ-035 Scenario: after reset, 10 pushes of 0x0..0x9 with pop_ready=0 -> count=10, FULL, push_ready=0; an 11th push_valid is not accepted.
REQ-036 Scenario: from FULL, 10 pops -> data 0x0..0x9 in order, then EMPTY, pop_valid=0.
REQ-037 Scenario: 25 cycles of continuous push and pop, both valid and ready -> pointers wrap 9->0 twice, count stays at 1 after the first cycle, and data order is preserved.
REQ-038 Scenario: count=6 with push_valid, pop_ready and flush all high -> next cycle count=0, EMPTY, and no entry accepted.
REQ-039 Scenario: rst_n low for one cycle at count=4 mid-stream -> pop_valid=0 asynchronously; next push of 0xAB pops as 0xAB.
REQ-040 Scenario with B_WORDLINE_FIFO_STATS_EN: fill to 7, flush, fill to 3 -> high_water=7.

Source files
------------

// File: rtl/mixedInclude_package.sv
// Shared definitions for the wordline FIFO slice.
// Provides the storage depth (BSIZE), the pointer/count width (BSIZE_LOG2),
// the pointer type, the FIFO state enum and the wrapping pointer-advance helper.
package mixedInclude_package;

  localparam int BSIZE      = 10;
  localparam int BSIZE_LOG2 = 4;

  typedef logic [BSIZE_LOG2-1:0] bptr_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } b_fifo_state_t;

  // Advance a pointer by one, wrapping from BSIZE-1 back to 0 so that the
  // unused codes BSIZE..2**BSIZE_LOG2-1 are never produced.
  function automatic bptr_t bptr_next(input bptr_t p);
    bptr_t n;
    if (p == bptr_t'(BSIZE - 1)) begin
      n = bptr_t'(0);
    end else begin
      n = p + bptr_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/b_wordline_ptr.sv
// Modulo-BSIZE wrap counter used for the FIFO read and write pointers.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (pointer -> 0)
//   clr   - synchronous clear, wins over inc
//   inc   - advance by one, wrapping BSIZE-1 -> 0
//   ptr   - current pointer value
module b_wordline_ptr
  import mixedInclude_package::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  inc,
  output bptr_t ptr
);

  bptr_t r_ptr;

  // Pointer register: clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= bptr_t'(0);
    end else if (clr) begin
      r_ptr <= bptr_t'(0);
    end else if (inc) begin
      r_ptr <= bptr_next(r_ptr);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/b_wordline_fifo.sv
// Ten-entry first-word-fall-through wordline FIFO with EMPTY/ACTIVE/FULL
// control FSM and a synchronous flush.
// Optional feature macro: B_WORDLINE_FIFO_STATS_EN adds the high_water port.
// Ports:
//   clk, rst_n       - clock (rising edge) and async active-low reset
//   flush            - synchronous clear of pointers/count/state (storage kept)
//   push_valid/ready - write handshake, push_data is the entry written
//   pop_valid/ready  - read handshake, pop_data is the oldest entry
//   count            - number of entries held, 0..BSIZE
//   high_water       - (stats build only) max count seen since reset
module b_wordline_fifo
  import mixedInclude_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [BSIZE_LOG2-1:0] count
`ifdef B_WORDLINE_FIFO_STATS_EN
  ,
  output logic [BSIZE_LOG2-1:0] high_water
`endif
);

  b_fifo_state_t         r_state;
  b_fifo_state_t         w_state_nxt;
  logic [BSIZE_LOG2-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_mem [BSIZE];
  bptr_t                 w_wr_ptr;
  bptr_t                 w_rd_ptr;
  logic                  w_push;
  logic                  w_pop;

  // Handshakes depend only on state, so ready/valid never see the partner's inputs.
  assign w_push = push_valid && push_ready;
  assign w_pop  = pop_valid && pop_ready;

  b_wordline_ptr u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (w_push),
    .ptr   (w_wr_ptr)
  );

  b_wordline_ptr u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (w_pop),
    .ptr   (w_rd_ptr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; flush overrides any handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) w_state_nxt = ACTIVE;
          else        w_state_nxt = EMPTY;
        end
        ACTIVE: begin
          if (w_push && !w_pop && (r_count == BSIZE_LOG2'(BSIZE - 1))) begin
            w_state_nxt = FULL;
          end else if (w_pop && !w_push && (r_count == BSIZE_LOG2'(1))) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = ACTIVE;
          end
        end
        FULL: begin
          if (w_pop) w_state_nxt = ACTIVE;
          else       w_state_nxt = FULL;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // FSM outputs, decoded straight from the state register.
  always_comb begin
    push_ready = (r_state != FULL);
    pop_valid  = (r_state != EMPTY);
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= BSIZE_LOG2'(0);
    end else if (flush) begin
      r_count <= BSIZE_LOG2'(0);
    end else if (w_push && !w_pop) begin
      r_count <= r_count + BSIZE_LOG2'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - BSIZE_LOG2'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Entry storage: never reset and untouched by flush.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[w_wr_ptr] <= push_data;
    end
  end

  assign count    = r_count;
  assign pop_data = r_mem[w_rd_ptr];

`ifdef B_WORDLINE_FIFO_STATS_EN
  logic [BSIZE_LOG2-1:0] r_high_water;

  // Peak occupancy, tracking the registered count so it lags by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_water <= BSIZE_LOG2'(0);
    end else if (r_count > r_high_water) begin
      r_high_water <= r_count;
    end else begin
      r_high_water <= r_high_water;
    end
  end

  assign high_water = r_high_water;
`endif

endmodule

// File: tb/tb_b_wordline_fifo.sv
module tb_b_wordline_fifo;

  localparam int DW = 32;
  localparam int BS = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [3:0]    count;
`ifdef B_WORDLINE_FIFO_STATS_EN
  logic [3:0]    high_water;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of stored entries plus the peak occupancy.
  logic [DW-1:0] mq[$];
  int            m_hw = 0;
  int            m_sz;
  bit            m_do_push;
  bit            m_do_pop;

  b_wordline_fifo #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count)
`ifdef B_WORDLINE_FIFO_STATS_EN
    ,
    .high_water (high_water)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model update at each active edge, from the spec's handshake rules.
  always @(posedge clk) begin
    if (rst_n) begin
      m_sz      = mq.size();
      m_do_push = push_valid && (m_sz < BS);
      m_do_pop  = pop_ready && (m_sz > 0);
      if (m_sz > m_hw) m_hw = m_sz;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_do_pop) void'(mq.pop_front());
        if (m_do_push) mq.push_back(push_data);
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    m_hw = 0;
  end

  // Every-cycle comparison on the inactive edge.
  always @(negedge clk) begin
    check("count", 64'(count), 64'(mq.size()));
    check("push_ready", 64'(push_ready), 64'(mq.size() != BS));
    check("pop_valid", 64'(pop_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check("pop_data", 64'(pop_data), 64'(mq[0]));
`ifdef B_WORDLINE_FIFO_STATS_EN
    check("high_water", 64'(high_water), 64'(m_hw));
`endif
  end

  // Wait for the next active edge (committing the previous inputs), then drive new ones.
  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
    @(posedge clk);
    #1;
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0; push_data = '0;
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_push_ready", 64'(push_ready), 64'd1);
    check("rst_pop_valid", 64'(pop_valid), 64'd0);
    do_reset();

    // Fill to FULL with 0..9, then offer an 11th entry.
    for (int i = 0; i < 10; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h0000_00EE, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd10);
    check("full_push_ready", 64'(push_ready), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_no_11th", 64'(count), 64'd10);

    // Drain in order.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_data", 64'(pop_data), 64'(i));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_pop_valid", 64'(pop_valid), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // Continuous streaming: 25 cycles of push+pop, pointers wrap twice.
    for (int k = 0; k < 25; k++) begin
      drive(1'b1, 32'h100 + DW'(k), 1'b1, 1'b0);
      if (k > 0) begin
        check("stream_count", 64'(count), 64'd1);
        check("stream_data", 64'(pop_data), 64'(32'h100 + k - 1));
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_last", 64'(pop_data), 64'h118);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("stream_empty", 64'(count), 64'd0);

    // Flush at count 6 while push and pop are both offered.
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h55, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_pop_valid", 64'(pop_valid), 64'd0);
    check("flush_push_ready", 64'(push_ready), 64'd1);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_flush_data", 64'(pop_data), 64'h77);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Async reset at count 4 mid-stream.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("prereset_count", 64'(count), 64'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pop_valid", 64'(pop_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'hAB, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_reset_valid", 64'(pop_valid), 64'd1);
    check("post_reset_data", 64'(pop_data), 64'hAB);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef B_WORDLINE_FIFO_STATS_EN
    // Peak survives flush: fill 7, flush, fill 3.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("hw_after_flush", 64'(high_water), 64'd7);
`endif

    // Randomized traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        int pp;
        int pq;
        pp = (ph == 0) ? 85 : (ph == 1) ? 20 : 55;
        pq = (ph == 0) ? 20 : (ph == 1) ? 85 : 55;
        drive(1'($urandom_range(99) < pp), DW'($urandom),
              1'($urandom_range(99) < pq), 1'($urandom_range(99) < 2));
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
